// File: rtl/joypad_scanner.sv
// NES-style serial pad scanner: periodic latch/shift, debounce, direction masking, group-select oP word.
// Latency: oButtons one cycle after the scan's last bit; oP one cycle after oButtons.
// Backpressure: none; the pad is polled free-running and outputs are always valid.
module joypad_scanner #(
    parameter int CLK_DIV     = 6,
    parameter int SCAN_PERIOD = 1024,
    parameter int DEB_SCANS   = 2,
    parameter int ALT_CYCLES  = 64
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iPadData,
    output logic       oPadLatch,
    output logic       oPadClk,
    output logic [7:0] oButtons,
    output logic       oValid,
    output logic [5:0] oP
);
    localparam int PW = $clog2(2 * CLK_DIV + 1);
    localparam int TW = $clog2(SCAN_PERIOD + 1);
    localparam int AW = $clog2(ALT_CYCLES + 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] PHASE_HIGH = PW'(CLK_DIV);
    localparam logic [TW-1:0] TMR_LAST   = TW'(SCAN_PERIOD - 1);
    localparam logic [AW-1:0] ALT_LAST   = AW'(ALT_CYCLES - 1);
    localparam logic [3:0]    DEB_MAX    = 4'(DEB_SCANS);

    typedef enum logic [1:0] {
        sIdle,
        sLatch,
        sShift,
        sDone
    } state_t;

    state_t        state;
    state_t        stateNext;
    logic [PW-1:0] phase;
    logic [PW-1:0] phaseNext;
    logic [2:0]    bitIdx;
    logic [2:0]    bitIdxNext;
    logic          sampleNow;
    logic [TW-1:0] scanTmr;
    logic          latchNext;
    logic          padClkNext;

    logic [7:0]    raw;
    logic [7:0]    prevRaw;
    logic [3:0]    matchCnt;
    logic [3:0]    matchNext;

    logic [3:0]    actGrp;
    logic [3:0]    dirGrp;
    logic          bothActive;
    logic [5:0]    pNext;
    logic [AW-1:0] altCnt;
    logic          showDir;

    // ---------------- scan FSM: state register ----------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= sIdle;
            phase   <= '0;
            bitIdx  <= '0;
            scanTmr <= '0;
            raw     <= '0;
        end else begin
            state   <= stateNext;
            phase   <= phaseNext;
            bitIdx  <= bitIdxNext;
            // Free-running period timer; zero marks a scan start, so the first scan follows reset at once.
            scanTmr <= (scanTmr == TMR_LAST) ? '0 : scanTmr + 1'b1;
            if (sampleNow) begin
                raw[bitIdx] <= ~iPadData;
            end
        end
    end

    // ---------------- scan FSM: next state ----------------
    always_comb begin
        stateNext  = state;
        phaseNext  = phase;
        bitIdxNext = bitIdx;
        sampleNow  = 1'b0;
        case (state)
            sIdle: begin
                if (scanTmr == '0) begin
                    stateNext  = sLatch;
                    phaseNext  = '0;
                    bitIdxNext = 3'd0;
                end
            end
            sLatch: begin
                if (phase == PHASE_LAST) begin
                    sampleNow  = 1'b1;
                    stateNext  = sShift;
                    phaseNext  = '0;
                    bitIdxNext = 3'd1;
                end else begin
                    phaseNext = phase + 1'b1;
                end
            end
            sShift: begin
                if (phase == PHASE_LAST) begin
                    sampleNow = 1'b1;
                    phaseNext = '0;
                    if (bitIdx == 3'd7) begin
                        stateNext = sDone;
                    end else begin
                        bitIdxNext = bitIdx + 3'd1;
                    end
                end else begin
                    phaseNext = phase + 1'b1;
                end
            end
            sDone: begin
                stateNext = sIdle;
            end
            default: begin
                stateNext = sIdle;
            end
        endcase
    end

    // ---------------- scan FSM: outputs (registered from next state) ----------------
    always_comb begin
        latchNext  = (stateNext == sLatch);
        padClkNext = (stateNext == sShift) && (phaseNext < PHASE_HIGH);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            oPadLatch <= 1'b0;
            oPadClk   <= 1'b0;
        end else begin
            oPadLatch <= latchNext;
            oPadClk   <= padClkNext;
        end
    end

    // ---------------- debounce ----------------
    always_comb begin
        matchNext = matchCnt;
        if (raw == prevRaw) begin
            if (matchCnt < DEB_MAX) begin
                matchNext = matchCnt + 4'd1;
            end
        end else begin
            matchNext = 4'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            prevRaw  <= '0;
            matchCnt <= '0;
            oButtons <= '0;
            oValid   <= 1'b0;
        end else begin
            oValid <= 1'b0;
            if (state == sDone) begin
                prevRaw  <= raw;
                matchCnt <= matchNext;
                if ((matchNext == DEB_MAX) && (raw != oButtons)) begin
                    oButtons <= raw;
                    oValid   <= 1'b1;
                end
            end
        end
    end

    // ---------------- group-select word ----------------
    // Opposing directions cancel on oP only; oButtons keeps the raw debounced state.
    always_comb begin
        actGrp     = oButtons[3:0];
        dirGrp     = {oButtons[5] & ~oButtons[4],
                      oButtons[4] & ~oButtons[5],
                      oButtons[6] & ~oButtons[7],
                      oButtons[7] & ~oButtons[6]};
        bothActive = (|actGrp) && (|dirGrp);
        pNext      = 6'b111111;
        if (bothActive) begin
            pNext = showDir ? {2'b01, ~dirGrp} : {2'b10, ~actGrp};
        end else if (|actGrp) begin
            pNext = {2'b10, ~actGrp};
        end else if (|dirGrp) begin
            pNext = {2'b01, ~dirGrp};
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            oP      <= 6'b111111;
            altCnt  <= '0;
            showDir <= 1'b0;
        end else begin
            oP <= pNext;
            if (bothActive) begin
                if (altCnt == ALT_LAST) begin
                    altCnt  <= '0;
                    showDir <= ~showDir;
                end else begin
                    altCnt <= altCnt + 1'b1;
                end
            end else begin
                altCnt  <= '0;
                showDir <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_joypad_scanner.sv
// Directed bench for joypad_scanner with a behavioural shift-register pad and an oValid scoreboard.
module tb_joypad_scanner;
    logic       Clock;
    logic       Reset;
    logic       iPadData;
    logic       oPadLatch;
    logic       oPadClk;
    logic [7:0] oButtons;
    logic       oValid;
    logic [5:0] oP;

    logic [7:0] padBtns = 8'h00;
    logic [7:0] padSh   = 8'hFF;
    logic       padClkD = 1'b0;

    logic [7:0] expQ[$];
    int         nChecks  = 0;
    int         nPass    = 0;
    int         nFail    = 0;
    int         validCnt = 0;
    logic [5:0] pAnd;

    joypad_scanner #(
        .CLK_DIV(6), .SCAN_PERIOD(1024), .DEB_SCANS(2), .ALT_CYCLES(64)
    ) dut (
        .Clock(Clock), .Reset(Reset), .iPadData(iPadData),
        .oPadLatch(oPadLatch), .oPadClk(oPadClk), .oButtons(oButtons),
        .oValid(oValid), .oP(oP)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Pad: parallel load while latched, shift on each rising pad clock, bit 0 on the data line.
    always @(posedge Clock) begin
        if (oPadLatch) padSh <= ~padBtns;
        else if (oPadClk && !padClkD) padSh <= {1'b1, padSh[7:1]};
        padClkD <= oPadClk;
    end
    assign iPadData = padSh[0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        assert (got === exp) nPass++;
        else begin
            nFail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every oValid pulse must match the oldest pending expected button word.
    always @(negedge Clock) begin
        if (oValid === 1'b1) begin
            validCnt++;
            chk("sbPending", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) chk("sbButtons", 32'(oButtons), 32'(expQ.pop_front()));
        end
    end

    task automatic waitLatchRise();
        int n = 0;
        @(negedge Clock);
        while (oPadLatch !== 1'b1 && n < 1100) begin
            @(negedge Clock);
            n++;
        end
        chk("latchRise", 32'(oPadLatch), 32'd1);
    endtask

    // Returns at the negedge of scan cycle 98, one cycle after oP has followed any oButtons change.
    task automatic runScan();
        waitLatchRise();
        repeat (98) begin
            @(negedge Clock);
            pAnd &= oP;
        end
    endtask

    // Called while the next posedge starts a scan; compares the pad waveform cycle by cycle.
    task automatic scanShape(input string tag);
        int mism = 0, pulses = 0, latchCyc = 0;
        logic prevClk = 1'b0, expLatch, expClk;
        for (int c = 0; c < 100; c++) begin
            @(negedge Clock);
            expLatch = (c < 12);
            expClk   = (c >= 12) && (c < 96) && (((c - 12) % 12) < 6);
            if (oPadLatch !== expLatch || oPadClk !== expClk) mism++;
            if (oPadClk === 1'b1 && !prevClk) pulses++;
            if (oPadLatch === 1'b1) latchCyc++;
            prevClk = oPadClk;
        end
        chk({tag, "_waveform"}, 32'(mism), 32'd0);
        chk({tag, "_latchCycles"}, 32'(latchCyc), 32'd12);
        chk({tag, "_pulses"}, 32'(pulses), 32'd7);
    endtask

    initial begin
        int mism;
        int vSnap;
        logic [5:0] expP;
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        chk("rstLatch", 32'(oPadLatch), 32'd0);
        chk("rstPadClk", 32'(oPadClk), 32'd0);
        chk("rstButtons", 32'(oButtons), 32'd0);
        chk("rstValid", 32'(oValid), 32'd0);
        chk("rstP", 32'(oP), 32'h3F);

        // First scan right after release.
        Reset = 1'b0;
        scanShape("scan0");

        // Single button A: accepted on the second matching scan.
        padBtns = 8'h01;
        expQ.push_back(8'h01);
        runScan();
        chk("aScan1Buttons", 32'(oButtons), 32'd0);
        chk("aScan1NoValid", 32'(validCnt), 32'd0);
        waitLatchRise();
        repeat (97) @(negedge Clock);
        chk("aValidPulse", 32'(oValid), 32'd1);
        chk("aButtons", 32'(oButtons), 32'h01);
        chk("aPBefore", 32'(oP), 32'h3F);
        @(negedge Clock);
        chk("aValidOneCycle", 32'(oValid), 32'd0);
        chk("aP", 32'(oP), 32'b101110);

        // Release, then a single-scan B glitch.
        padBtns = 8'h00;
        expQ.push_back(8'h00);
        runScan();
        runScan();
        chk("relButtons", 32'(oButtons), 32'd0);
        chk("relP", 32'(oP), 32'h3F);
        vSnap = validCnt;
        pAnd = 6'h3F;
        padBtns = 8'h02;
        runScan();
        padBtns = 8'h00;
        repeat (3) runScan();
        chk("glitchButtons", 32'(oButtons), 32'd0);
        chk("glitchNoValid", 32'(validCnt), 32'(vSnap));
        chk("glitchPIdle", 32'(pAnd), 32'h3F);

        // Start+Right: groups alternate every 64 cycles, action first.
        padBtns = 8'h88;
        expQ.push_back(8'h88);
        runScan();
        runScan();
        chk("bothButtons", 32'(oButtons), 32'h88);
        chk("bothFirstP", 32'(oP), 32'b100111);
        mism = 0;
        for (int i = 0; i < 192; i++) begin
            expP = ((i / 64) % 2 == 1) ? 6'b011110 : 6'b100111;
            if (oP !== expP) mism++;
            @(negedge Clock);
        end
        chk("bothAlternation", 32'(mism), 32'd0);

        // Up+Down+Left: opposing pair cancels on oP only.
        padBtns = 8'h70;
        expQ.push_back(8'h70);
        runScan();
        runScan();
        chk("maskButtons", 32'(oButtons), 32'h70);
        chk("maskP", 32'(oP), 32'b011101);

        // Reset during the bit-4 high phase.
        waitLatchRise();
        repeat (50) @(negedge Clock);
        chk("midBit4High", 32'(oPadClk), 32'd1);
        Reset = 1'b1;
        padBtns = 8'h01;
        expQ.push_back(8'h01);
        @(negedge Clock);
        chk("midPadClk", 32'(oPadClk), 32'd0);
        chk("midLatch", 32'(oPadLatch), 32'd0);
        chk("midP", 32'(oP), 32'h3F);
        chk("midButtons", 32'(oButtons), 32'd0);
        Reset = 1'b0;
        scanShape("postRst");
        chk("postRstScan1Buttons", 32'(oButtons), 32'd0);
        runScan();
        chk("postRstButtons", 32'(oButtons), 32'h01);
        chk("postRstP", 32'(oP), 32'b101110);
        chk("sbDrained", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule

// File: doc/joypad_scanner.md
# joypad_scanner

Drives an external NES-style serial gamepad (latch, clock, data) and produces the 6-bit active-low joypad word consumed by the `io` joypad block. It periodically shifts out the pad's 8 buttons, debounces them across scans, masks impossible direction combinations, and presents the result on `oP` using the group-select encoding. When both button groups are active, the two groups are time-multiplexed on `oP`.

## Interface
Parameters:
- `CLK_DIV`, default 6: half-period of `oPadClk`, in `Clock` cycles. Must be ≥1.
- `SCAN_PERIOD`, default 1024: `Clock` cycles from one scan start to the next. Must be ≥ 16*`CLK_DIV`+2.
- `DEB_SCANS`, default 2: number of consecutive identical scans required to accept a new button state. Range 1..15.
- `ALT_CYCLES`, default 64: `Clock` cycles each group is shown on `oP` when both groups are active.

Ports:
- `Clock` input 1: the single clock; all logic is on the rising edge.
- `Reset` input 1: synchronous, active-high.
- `iPadData` input 1: serial data from the pad. Active-low (0 = pressed). Already synchronised.
- `oPadLatch` output 1: pad latch/strobe, active-high.
- `oPadClk` output 1: pad shift clock.
- `oButtons` output 8: debounced buttons, active-high. Bit order: [0]A, [1]B, [2]Select, [3]Start, [4]Up, [5]Down, [6]Left, [7]Right.
- `oValid` output 1: one-cycle pulse when `oButtons` changes.
- `oP` output 6: joypad word for `io`, active-low.
  - [5:4] = 2'b10: action group. [3:0] = {Start, Select, B, A}.
  - [5:4] = 2'b01: direction group. [3:0] = {Down, Up, Left, Right}.
  - 6'b111111: idle.

## Operation
- All outputs are registered.
- Reset values: `oPadLatch`=0, `oPadClk`=0, `oButtons`=0, `oValid`=0, `oP`=6'b111111. Reset also clears the debounce state, the scan timer, and the group toggle to the action group.
- FSM states: IDLE → LATCH → SHIFT → DONE → IDLE.
  - **IDLE:** wait until the scan timer expires, then enter LATCH.
  - **LATCH:** `oPadLatch`=1 for 2*`CLK_DIV` cycles. `iPadData` is sampled on the last LATCH cycle as bit 0 (A).
  - **SHIFT:** for bits k=1..7, drive `oPadClk`=1 for `CLK_DIV` cycles, then `oPadClk`=0 for `CLK_DIV` cycles. Bit k is sampled on the last low cycle. This gives exactly 7 `oPadClk` pulses per scan.
  - **DONE:** one cycle; runs the debounce step, then return to IDLE.
- Sampled bits are inverted into `raw[7:0]`, so 1 = pressed.
- Debounce step, in DONE:
  - If `raw` == `prev_raw`, the match count increments, saturating at `DEB_SCANS`.
  - Otherwise `prev_raw` is set to `raw` and the count is set to 1.
  - When the count equals `DEB_SCANS` and `raw` ≠ `oButtons`: load `oButtons` with `raw` and pulse `oValid`.
- Direction masking, applied to `oP` only (never to `oButtons`):
  - Up and Down both pressed: both treated as released.
  - Left and Right both pressed: both treated as released.
- `oP` selection, evaluated every cycle from the masked buttons:
  - Only the action group is non-zero: show the action group.
  - Only the direction group is non-zero: show the direction group.
  - Both non-zero: alternate groups every `ALT_CYCLES` cycles, starting with the action group. The toggle counter resets whenever either group becomes zero.
  - Neither non-zero: 6'b111111.

## Timing
- First scan: `oPadLatch` goes to 1 on the first edge at which `Reset` is sampled low.
- Scan length is 16*`CLK_DIV`+1 cycles, LATCH start through DONE.
- Scan start period: a new LATCH begins exactly `SCAN_PERIOD` cycles after the previous LATCH start.
- `oButtons` and `oValid` update on the edge that ends DONE. `oValid` is high for exactly one cycle.
- `oP` reflects new `oButtons` one cycle after `oButtons` changes.
- Reset mid-scan: the scan is aborted and all outputs take their reset values on the next edge. The partial `raw` is discarded, with no debounce update.
- `oPadLatch` and `oPadClk` are never high simultaneously.

## Test plan
- **Reset:** hold `Reset` for 3 cycles → all outputs at reset values. On release, `oPadLatch`=1 for 12 cycles (`CLK_DIV`=6), then exactly 7 `oPadClk` pulses, each 6 cycles high and 6 cycles low.
- **Single button:** pad model presses A (bit 0 low) on every scan, `DEB_SCANS`=2. After scan 1: `oButtons`=0, no `oValid`. After scan 2's DONE: `oButtons`=8'h01 and `oValid` pulses. One cycle later, `oP`=6'b101110.
- **Glitch rejection:** B pressed in one scan only, surrounded by no-press scans → `oButtons` stays 8'h00, `oValid` never asserts, and `oP` stays 6'b111111.
- **Both groups active:** Start+Right held → `oButtons`=8'h88. `oP` alternates 6'b100111 and 6'b011110, each held for 64 cycles, starting with 6'b100111.
- **Direction masking:** Up+Down+Left held → `oButtons`=8'h70 and `oP`=6'b011101.
- **Reset mid-scan:** assert `Reset` during the bit-4 high phase → next cycle `oPadClk`=0, `oPadLatch`=0, and `oP`=6'b111111. The following scan runs complete and aligned, with 7 pulses. `oButtons` only updates after `DEB_SCANS` full scans.
